// File: rtl/ps2_pkg.sv
// Shared constants, frame-state encoding and frame check helper for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] EXT_PREFIX   = 8'hE0;
  localparam int         FRAME_BITS   = 11;

  localparam logic [7:0] KEY_W = 8'h1D;
  localparam logic [7:0] KEY_Q = 8'h15;
  localparam logic [7:0] KEY_E = 8'h24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } frame_state_t;

  // bits = {stop, parity, data[7:0]}; odd parity over data+parity and a high stop bit
  function automatic logic frame_ok(input logic [FRAME_BITS-2:0] bits);
    return (^bits[8:0]) & bits[9];
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser on both PS/2 lines, glitch filter on the clock line
// and a one-cycle strobe when the filtered clock falls.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_f,
  output logic data_s,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
  logic [CW-1:0] cnt_r;
  logic          clk_f_r, fall_r;
  logic          flip_s;

  // last of FILTER_LEN consecutive samples that disagree with the filtered level
  assign flip_s = (clk_sync_r != clk_f_r) && (cnt_r == CW'(FILTER_LEN - 1));

  // synchronisers; idle-high so a reset never fakes a falling edge
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
    end
  end

  // run-length filter and falling-edge strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= '0;
      clk_f_r <= 1'b1;
      fall_r  <= 1'b0;
    end else begin
      fall_r <= flip_s & clk_f_r;
      if (clk_sync_r == clk_f_r) begin
        cnt_r <= '0;
      end else if (flip_s) begin
        cnt_r   <= '0;
        clk_f_r <= clk_sync_r;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign clk_f  = clk_f_r;
  assign data_s = data_sync_r;
  assign fall   = fall_r;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames, tracks F0/E0 prefixes and
// holds the last decoded key as a level for a slowly sampling controller.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 5400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       released,
  output logic       extended,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = FRAME_BITS - 1;

  frame_state_t  state_r, state_s;
  logic          clk_f_unused, data_s, fall_s;
  logic [FW-1:0] shift_r;
  logic [3:0]    bitcnt_r;
  logic [TW-1:0] tmo_r;
  logic          err_s, accept_s, expire_s;
  logic          brk_pend_r, ext_pend_r;
  logic [7:0]    data_r;
  logic          released_r, extended_r, code_valid_r, frame_err_r;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .clk_f    (clk_f_unused),
    .data_s   (data_s),
    .fall     (fall_s)
  );

  assign expire_s = (tmo_r == TW'(TIMEOUT_CYCLES - 1));

  // frame state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // frame next-state; a fall always wins over a coincident timeout
  always_comb begin
    state_s  = state_r;
    err_s    = 1'b0;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (fall_s) begin
          if (data_s) err_s   = 1'b1;
          else        state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (fall_s) begin
          if (bitcnt_r == 4'(FW - 1)) state_s = CHECK;
          else                        state_s = SHIFT;
        end else if (expire_s) begin
          err_s   = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = SHIFT;
        end
      end
      CHECK: begin
        state_s = IDLE;
        if (frame_ok(shift_r)) accept_s = 1'b1;
        else                   err_s    = 1'b1;
      end
      default: state_s = IDLE;
    endcase
  end

  // shift register, bit counter and inter-edge timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r  <= '0;
      bitcnt_r <= 4'd0;
      tmo_r    <= '0;
    end else begin
      if (fall_s)                 tmo_r <= '0;
      else if (state_r == SHIFT)  tmo_r <= tmo_r + TW'(1);
      else                        tmo_r <= '0;
      if (state_r == IDLE) begin
        bitcnt_r <= 4'd0;
      end else if ((state_r == SHIFT) && fall_s) begin
        shift_r  <= {data_s, shift_r[FW-1:1]};
        bitcnt_r <= bitcnt_r + 4'd1;
      end
    end
  end

  // prefix decoder and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      brk_pend_r   <= 1'b0;
      ext_pend_r   <= 1'b0;
      data_r       <= 8'h00;
      released_r   <= 1'b0;
      extended_r   <= 1'b0;
      code_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      code_valid_r <= 1'b0;
      frame_err_r  <= err_s;
      if (accept_s) begin
        if (shift_r[7:0] == BREAK_PREFIX) begin
          brk_pend_r <= 1'b1;
        end else if (shift_r[7:0] == EXT_PREFIX) begin
          ext_pend_r <= 1'b1;
        end else begin
          data_r       <= shift_r[7:0];
          released_r   <= brk_pend_r;
          extended_r   <= ext_pend_r;
          code_valid_r <= 1'b1;
          brk_pend_r   <= 1'b0;
          ext_pend_r   <= 1'b0;
        end
      end
    end
  end

  assign data       = data_r;
  assign released   = released_r;
  assign extended   = extended_r;
  assign code_valid = code_valid_r;
  assign frame_err  = frame_err_r;

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
Receives the PS/2 keyboard serial stream and presents decoded scan codes to the motor controller as `data[7:0]` and `released`. It sits between the board's PS/2 pins and the controller. It synchronises and deglitches the PS/2 lines, deframes 11-bit frames, and tracks the F0 (break) and E0 (extended) prefixes. It holds the last decoded key as a level, because downstream logic samples it on a slow clock.

Parameters:
- FILTER_LEN, 8: consecutive equal `clk` samples required before the filtered `ps2_clk` changes state.
- TIMEOUT_CYCLES, 5400: maximum `clk` cycles allowed between falling edges inside a frame (200 us at 27 MHz) before the frame is aborted.

Ports:
- clk  in  1  system clock, 27 MHz
- rst  in  1  synchronous, active-high reset
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous
- ps2_data  in  1  raw PS/2 data pin, asynchronous
- data  out  8  last decoded scan code, held as a level
- released  out  1  1 = last event was a break (key up); 0 = make (key down)
- extended  out  1  1 = last code was preceded by E0
- code_valid  out  1  one-cycle pulse when `data`/`released`/`extended` update
- frame_err  out  1  one-cycle pulse on a parity, start, stop or timeout error

Behaviour:
- Clock and reset: single clock domain `clk`. Reset is synchronous and active-high on `rst`.
- Reset values: `data` = 8'h00, `released` = 0, `extended` = 0, `code_valid` = 0, `frame_err` = 0. Reset also sets the frame FSM to IDLE, clears the prefix flags, sets the filtered clock to 1 and clears the timeout counter. `rst` asserted mid-frame discards the partial frame; nothing is emitted.
- Input synchronisation: two flip-flops each on `ps2_clk` and `ps2_data`.
- Clock filter: the filtered `ps2_clk` changes only after FILTER_LEN consecutive identical synchronised samples. The falling-edge strobe `fall` is a one-cycle pulse when the filtered clock goes 1->0.
- Data sampling: the synchronised `ps2_data` is sampled on the `fall` cycle.
- Frame FSM, IDLE:
  - On `fall` with data = 0 (start bit), go to SHIFT with `bitcnt` = 0.
  - On `fall` with data = 1, stay in IDLE and pulse `frame_err`.
- Frame FSM, SHIFT:
  - On each `fall`, shift data in LSB first.
  - Bits 0-7 are data, bit 8 is odd parity, bit 9 is the stop bit.
  - After the stop-bit `fall`, go to CHECK.
- Frame FSM, CHECK (one cycle):
  - Valid frame: XOR of the 8 data bits and the parity bit = 1, and stop = 1. Pass the byte to the decoder and return to IDLE.
  - Otherwise pulse `frame_err`, discard the byte and return to IDLE.
- Timeout: the counter clears on every `fall` and counts in SHIFT. When it reaches TIMEOUT_CYCLES, pulse `frame_err`, go to IDLE and discard the byte. Prefix flags are kept.
- Decoder, byte F0: set `brk_pend`. No output.
- Decoder, byte E0: set `ext_pend`. No output.
- Decoder, any other byte:
  - `data` <= byte, `released` <= `brk_pend`, `extended` <= `ext_pend`.
  - Pulse `code_valid`.
  - Clear both pending flags.
- Decoder, repeated prefixes: F0 F0 keeps `brk_pend` = 1. E0 F0 X yields `extended` = 1, `released` = 1.
- Latency: `code_valid` and the updated outputs appear exactly 2 `clk` cycles after the stop-bit `fall` strobe (CHECK, then register).
- Simultaneous events: `fall` and timeout expiry in the same cycle resolve as `fall` (the counter clears).
- No host-to-device transmission. The pins are inputs only.

Decomposition:
- Shared package `ps2_pkg`:
  - constants BREAK_PREFIX = 8'hF0 and EXT_PREFIX = 8'hE0;
  - FRAME_BITS = 11;
  - frame FSM state encoding IDLE/SHIFT/CHECK;
  - key codes used by the motor controller: KEY_W = 8'h1D, KEY_Q = 8'h15, KEY_E = 8'h24.
- Sub-module `ps2_line_filter`: two-flop synchroniser plus FILTER_LEN glitch filter and falling-edge strobe, producing `clk_f`, `data_s` and `fall`. The top module holds the frame FSM and the prefix decoder.

Test Plan:
- Make code: frame for 8'h1D (parity 1, 12.5 kHz PS/2 clock) -> one `code_valid` pulse; `data` = 8'h1D, `released` = 0, `extended` = 0; `frame_err` never asserts.
- Break sequence: frames F0 then 15 -> exactly one `code_valid`, after the 15 frame; `data` = 8'h15, `released` = 1. A following 24 frame -> `data` = 8'h24, `released` = 0.
- Extended break: frames E0, F0, 75 -> single `code_valid`; `data` = 8'h75, `released` = 1, `extended` = 1.
- Errors:
  - frame 1D with the parity bit flipped -> `frame_err` pulse, no `code_valid`, `data` unchanged;
  - a bad stop bit (0) -> same result.
- Timeout and glitch:
  - stop `ps2_clk` after 5 bits -> `frame_err` 5400 cycles after the last `fall`, then a clean 1D frame decodes correctly;
  - 3-cycle low glitches on `ps2_clk` -> ignored.
- Reset mid-frame: assert `rst` for 1 cycle after F0 plus 4 bits of the next frame -> all outputs 0. The next full frame 1D gives `released` = 0, confirming the prefix flag was cleared.
